// File: rtl/imem_loader_pkg.sv
// Shared types and stream-format constants for the instruction-memory boot loader.
// Build option IMEM_LOADER_CHECKSUM_EN adds the trailing checksum phase.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN0,
        ST_LEN1,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERROR
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int LEN_BYTES      = 2;
    localparam int CSUM_BYTES     = 4;

    // States in which the loader consumes stream bytes.
    function automatic logic takes_bytes(input state_t s);
        return (s == ST_LEN0) || (s == ST_LEN1) || (s == ST_DATA) || (s == ST_CSUM);
    endfunction

endpackage

// File: rtl/byte_assembler.sv
// Little-endian 8-to-32 packer; word/word_valid include the byte being accepted
// this cycle so the caller can register the finished word with no extra latency.
module byte_assembler
    import imem_loader_pkg::*;
(
    input  logic        CLK,
    input  logic        resetl,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_valid,
    output logic        len_valid
);

    logic [1:0]  cnt;
    logic [31:0] sh;

    always_comb begin
        word = sh;
        word[{cnt, 3'b000} +: 8] = byte_in;
    end

    assign word_valid = byte_en && (cnt == 2'(BYTES_PER_WORD - 1));
    assign len_valid  = byte_en && (cnt == 2'(LEN_BYTES - 1));

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            cnt <= '0;
            sh  <= '0;
        end else if (clear) begin
            cnt <= '0;
            sh  <= '0;
        end else if (byte_en) begin
            cnt <= cnt + 2'd1;
            sh  <= word;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction RAM writer: length header, LE words, optional checksum.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing 32-bit wrapping-sum checksum.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR = 64'h0,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic        CLK,
    input  logic        resetl,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        wr_en,
    output logic [63:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        cpu_hold,
    output logic        done,
    output logic        error,
    output logic [15:0] words_loaded
);

    state_t      state_q, state_n;
    logic        accept, load_go, asm_clear, len_take;
    logic        word_valid, len_valid, last_word;
    logic        wr_go, fin_set, fin_q;
    logic [31:0] word;
    logic [15:0] len, n_words;
    logic [63:0] next_addr;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] csum_acc;
`endif

    assign accept    = in_valid && in_ready;
    assign load_go   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERROR));
    assign len       = word[15:0];
    assign len_take  = (state_q == ST_LEN1) && len_valid;
    assign asm_clear = load_go || len_take;
    assign last_word = (words_loaded + 16'd1) == n_words;

    byte_assembler u_asm (
        .CLK        (CLK),
        .resetl     (resetl),
        .clear      (asm_clear),
        .byte_en    (accept),
        .byte_in    (in_data),
        .word       (word),
        .word_valid (word_valid),
        .len_valid  (len_valid)
    );

    always_comb begin
        state_n = state_q;
        wr_go   = 1'b0;
        fin_set = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (load_go) state_n = ST_LEN0;
            end
            ST_LEN0: begin
                if (accept) state_n = ST_LEN1;
            end
            ST_LEN1: begin
                if (len_valid) begin
                    if ({16'd0, len} > MAX_WORDS) state_n = ST_ERROR;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    else if (len == 16'd0)        state_n = ST_CSUM;
`else
                    else if (len == 16'd0)        state_n = ST_DONE;
`endif
                    else                          state_n = ST_DATA;
                end
            end
            ST_DATA: begin
                // fin_q marks the cycle the final write is on the bus; done follows it.
                if (fin_q) begin
                    state_n = ST_DONE;
                end else if (word_valid) begin
                    wr_go = 1'b1;
                    if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_n = ST_CSUM;
`else
                        fin_set = 1'b1;
`endif
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (word_valid) state_n = (word == csum_acc) ? ST_DONE : ST_ERROR;
            end
`endif
            default: state_n = ST_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            state_q      <= ST_IDLE;
            in_ready     <= 1'b0;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            words_loaded <= '0;
            n_words      <= '0;
            next_addr    <= BASE_ADDR;
            fin_q        <= 1'b0;
        end else begin
            state_q  <= state_n;
            in_ready <= takes_bytes(state_n) && !fin_set;
            cpu_hold <= (state_n != ST_DONE);
            done     <= (state_n == ST_DONE);
            error    <= (state_n == ST_ERROR);
            wr_en    <= wr_go;
            fin_q    <= fin_set;
            if (load_go) begin
                words_loaded <= '0;
                next_addr    <= BASE_ADDR;
            end else if (wr_go) begin
                wr_addr      <= next_addr;
                wr_data      <= word;
                next_addr    <= next_addr + 64'd4;
                words_loaded <= words_loaded + 16'd1;
            end
            if (len_take) n_words <= len;
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl)     csum_acc <= '0;
        else if (load_go) csum_acc <= '0;
        else if (wr_go)  csum_acc <= csum_acc + word;
    end
`endif

endmodule
